// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-pc select encoding and FSM state.
package pc_pkg;

  typedef enum logic [2:0] {
    PcSeq    = 3'd0,
    PcBranch = 3'd1,
    PcJump   = 3'd2,
    PcCall   = 3'd3,
    PcRet    = 3'd4
  } pc_sel_t;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_t;

endpackage

// File: rtl/pc_if.sv
// Fetch-control bundle between the sequencer (master) and pc_unit (slave).
interface pc_if #(
  parameter int unsigned ADDR_W = 32
);
  import pc_pkg::*;

  logic              stall;
  pc_sel_t           pc_sel;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              halted;
  logic              ras_err;

  modport master (
    output stall, pc_sel, target, offset,
    input  pc, pc_valid, halted, ras_err
  );

  modport slave (
    input  stall, pc_sel, target, offset,
    output pc, pc_valid, halted, ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when PC_RAS_EN is defined.
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(RAS_DEPTH):0] depth
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   top_ptr;
  logic [CntW-1:0]   depth_q;

  assign top_ptr  = wr_ptr_q - 1'b1;
  assign top_data = mem_q[top_ptr];
  assign full     = (depth_q == CntW'(RAS_DEPTH));
  assign empty    = (depth_q == '0);
  assign depth    = depth_q;

  // Clearing depth is enough to discard contents; the storage itself needs no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      depth_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (!full) depth_q <= depth_q + 1'b1;
    end else if (pop) begin
      wr_ptr_q <= top_ptr;
      depth_q  <= depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assert property (@(posedge clk) disable iff (reset) !(pop && empty));
  assert property (@(posedge clk) disable iff (reset) !(push && pop));

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencer with branch/jump/call/return select.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL=JUMP and RET=SEQ.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] FIRST_ADDRESS = '0,
  parameter logic [ADDR_W-1:0] PC_INC        = ADDR_W'(4),
  parameter logic [ADDR_W-1:0] HALT_ADDR     = ADDR_W'('h7C),
  parameter int unsigned       RAS_DEPTH     = 4
) (
  input logic clk,
  input logic reset,
  pc_if.slave bus
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  state_t            state_q, state_d;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_pc, next_pc;
  logic              advance;

  assign sel     = bus.pc_sel;
  assign seq_pc  = pc_q + PC_INC;
  assign advance = (state_q == StRun) && !bus.stall;

`ifdef PC_RAS_EN
  logic                       ras_push, ras_pop, ras_full, ras_empty;
  logic                       ras_err_q, ras_err_d;
  logic [ADDR_W-1:0]          ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_depth;

  assign ras_push  = advance && (sel == PcCall);
  assign ras_pop   = advance && (sel == PcRet) && !ras_empty;
  assign ras_err_d = advance && (((sel == PcCall) && ras_full) ||
                                 ((sel == PcRet) && ras_empty));

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .depth     (ras_depth)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ras_err_q <= 1'b0;
    else       ras_err_q <= ras_err_d;
  end

  assert property (@(posedge clk) disable iff (reset) ras_empty == (ras_depth == '0));
`endif

  // Next-pc select; unknown encodings fall through to sequential.
  always_comb begin
    next_pc = seq_pc;
    case (sel)
      PcBranch:       next_pc = pc_q + bus.offset;
      PcJump, PcCall: next_pc = bus.target;
`ifdef PC_RAS_EN
      PcRet:          next_pc = ras_empty ? seq_pc : ras_top;
`endif
      default:        next_pc = seq_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        pc_d    = FIRST_ADDRESS;
      end
      StRun: begin
        if (!bus.stall) begin
          pc_d = next_pc;
          if (next_pc == HALT_ADDR) state_d = StHalt;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    bus.pc       = pc_q;
    bus.pc_valid = (state_q != StBoot);
    bus.halted   = (state_q == StHalt);
`ifdef PC_RAS_EN
    bus.ras_err  = ras_err_q;
`else
    bus.ras_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main function and an
// 8-bit instance for address wrap. RAS scenarios follow PC_RAS_EN.
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [34:0] got, exp;
  logic [10:0] got8, exp8;

  pc_if #(.ADDR_W(32)) bus ();
  pc_if #(.ADDR_W(8))  bus8 ();

  pc_unit #(
    .ADDR_W        (32),
    .FIRST_ADDRESS (32'h100),
    .PC_INC        (32'd4),
    .HALT_ADDR     (32'h7C),
    .RAS_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_unit #(
    .ADDR_W        (8),
    .FIRST_ADDRESS (8'hFC),
    .PC_INC        (8'd4),
    .HALT_ADDR     (8'h7C),
    .RAS_DEPTH     (4)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [34:0] obs();
    return {bus.pc, bus.pc_valid, bus.halted, bus.ras_err};
  endfunction

  function automatic logic [10:0] obs8();
    return {bus8.pc, bus8.pc_valid, bus8.halted, bus8.ras_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pc_sel_t sel, input logic [31:0] tgt, input logic [31:0] off);
    bus.pc_sel = sel;
    bus.target = tgt;
    bus.offset = off;
  endtask

  // Reset, release, and take the boot edge: pc lands on FIRST_ADDRESS.
  task automatic restart();
    reset = 1'b1;
    bus.stall = 1'b0;
    drive(PcSeq, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    n_cmp++; got = obs(); exp = {32'h0, 3'b000};
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, exp); end
    n_cmp++; got8 = obs8(); exp8 = {8'h0, 3'b000};
    if (got8 !== exp8) begin n_fail++; $display("FAIL reset_state8: got %h want %h", got8, exp8); end
  endtask

  task automatic test_seq();
    reset = 1'b0;
    step();
    n_cmp++; got = obs(); exp = {32'h100, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL boot_first: got %h want %h", got, exp); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; got = obs(); exp = {32'h100 + 32'(4 * i), 3'b100};
      if (got !== exp) begin n_fail++; $display("FAIL seq_%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_branch_jump_stall();
    drive(PcJump, 32'h200, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h200, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL jump_200: got %h want %h", got, exp); end
    drive(PcBranch, 32'h0, 32'hFFFF_FFF0);
    step();
    n_cmp++; got = obs(); exp = {32'h1F0, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL branch_back: got %h want %h", got, exp); end
    drive(PcJump, 32'h40, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h40, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL jump_40: got %h want %h", got, exp); end
    bus.stall = 1'b1;
    drive(PcJump, 32'h999, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; got = obs(); exp = {32'h40, 3'b100};
      if (got !== exp) begin n_fail++; $display("FAIL stall_%0d: got %h want %h", i, got, exp); end
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_undefined_sel();
    for (int i = 0; i < 3; i++) begin
      drive(pc_sel_t'(3'(5 + i)), 32'h888, 32'h100);
      step();
      n_cmp++; got = obs(); exp = {32'h40 + 32'(4 * (i + 1)), 3'b100};
      if (got !== exp) begin n_fail++; $display("FAIL undef_sel_%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_wrap32();
    drive(PcJump, 32'hFFFF_FFFC, 32'h0);
    step();
    drive(PcSeq, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h0, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL wrap32: got %h want %h", got, exp); end
  endtask

  task automatic test_call_ret();
    logic [31:0] want [4];
`ifdef PC_RAS_EN
    want = '{32'h300, 32'h400, 32'h304, 32'h14};
`else
    want = '{32'h300, 32'h400, 32'h404, 32'h408};
`endif
    drive(PcJump, 32'h10, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(PcCall, 32'h300 + 32'(i * 'h100), 32'h0);
      else       drive(PcRet, 32'h0, 32'h0);
      step();
      n_cmp++; got = obs(); exp = {want[i], 3'b100};
      if (got !== exp) begin n_fail++; $display("FAIL call_ret_%0d: got %h want %h", i, got, exp); end
    end
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras_overflow();
    logic [31:0] rets [4];
    rets = '{32'h5004, 32'h4004, 32'h3004, 32'h2004};
    drive(PcJump, 32'h1000, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(PcCall, 32'h2000 + 32'(i * 'h1000), 32'h0);
      step();
      n_cmp++; got = obs(); exp = {32'h2000 + 32'(i * 'h1000), 2'b10, (i == 4)};
      if (got !== exp) begin n_fail++; $display("FAIL overflow_call_%0d: got %h want %h", i, got, exp); end
    end
    bus.stall = 1'b1;
    drive(PcRet, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h6000, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL stall_err_low: got %h want %h", got, exp); end
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; got = obs(); exp = {rets[i], 3'b100};
      if (got !== exp) begin n_fail++; $display("FAIL overflow_ret_%0d: got %h want %h", i, got, exp); end
    end
    step();
    n_cmp++; got = obs(); exp = {32'h2008, 3'b101};
    if (got !== exp) begin n_fail++; $display("FAIL underflow_ret: got %h want %h", got, exp); end
    drive(PcSeq, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h200C, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL err_one_cycle: got %h want %h", got, exp); end
  endtask

  task automatic test_ras_reset_discard();
    drive(PcCall, 32'h500, 32'h0);
    step();
    drive(PcCall, 32'h600, 32'h0);
    step();
    bus.stall = 1'b1;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    step();
    n_cmp++; got = obs(); exp = {32'h100, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL reboot_pc: got %h want %h", got, exp); end
    bus.stall = 1'b0;
    drive(PcRet, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h104, 3'b101};
    if (got !== exp) begin n_fail++; $display("FAIL ras_discarded: got %h want %h", got, exp); end
  endtask
`endif

  task automatic test_halt();
    restart();
    drive(PcJump, 32'h7C, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h7C, 3'b110};
    if (got !== exp) begin n_fail++; $display("FAIL halt_enter: got %h want %h", got, exp); end
    drive(PcJump, 32'h200, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h7C, 3'b110};
    if (got !== exp) begin n_fail++; $display("FAIL halt_jump: got %h want %h", got, exp); end
    drive(PcSeq, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h7C, 3'b110};
    if (got !== exp) begin n_fail++; $display("FAIL halt_seq: got %h want %h", got, exp); end
    reset = 1'b1;
    #2;
    n_cmp++; got = obs(); exp = {32'h0, 3'b000};
    if (got !== exp) begin n_fail++; $display("FAIL async_reset: got %h want %h", got, exp); end
    reset = 1'b0;
    step();
    n_cmp++; got = obs(); exp = {32'h100, 3'b100};
    if (got !== exp) begin n_fail++; $display("FAIL halt_reboot: got %h want %h", got, exp); end
    drive(PcJump, 32'h78, 32'h0);
    step();
    drive(PcSeq, 32'h0, 32'h0);
    step();
    n_cmp++; got = obs(); exp = {32'h7C, 3'b110};
    if (got !== exp) begin n_fail++; $display("FAIL halt_via_seq: got %h want %h", got, exp); end
  endtask

  task automatic test_wrap8();
    bus8.stall = 1'b1;
    restart();
    n_cmp++; got8 = obs8(); exp8 = {8'hFC, 3'b100};
    if (got8 !== exp8) begin n_fail++; $display("FAIL wrap8_first: got %h want %h", got8, exp8); end
    bus8.stall = 1'b0;
    step();
    n_cmp++; got8 = obs8(); exp8 = {8'h00, 3'b100};
    if (got8 !== exp8) begin n_fail++; $display("FAIL wrap8: got %h want %h", got8, exp8); end
    bus8.stall = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    drive(PcSeq, 32'h0, 32'h0);
    bus8.stall  = 1'b1;
    bus8.pc_sel = PcSeq;
    bus8.target = 8'h0;
    bus8.offset = 8'h0;
    test_reset();
    test_seq();
    test_branch_jump_stall();
    test_undefined_sel();
    test_wrap32();
    test_call_ret();
`ifdef PC_RAS_EN
    test_ras_overflow();
    test_ras_reset_discard();
`endif
    test_halt();
    test_wrap8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
